// File: rtl/onehot_encoder_pipe_if.sv
// Handshake bundle for onehot_encoder_pipe: input beat channel plus registered result channel.
interface onehot_encoder_pipe_if #(
  parameter int N = 8
);
  localparam int W = (N > 2) ? $clog2(N) : 1;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_err;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_err
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_err
  );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// One-hot / priority encoder behind a single registered stage, 1-cycle latency, full throughput.
// Optional saturating error-beat counter enabled by macro ONEHOT_ENC_ERR_CNT_EN.
module onehot_encoder_pipe #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef ONEHOT_ENC_ERR_CNT_EN
  input  logic                   err_clr,
  output logic [15:0]            err_cnt,
`endif
  onehot_encoder_pipe_if.slave   bus
);
  localparam int W = (N > 2) ? $clog2(N) : 1;

  logic         out_valid_q;
  logic [W-1:0] out_idx_q;
  logic         out_err_q;
  logic [W-1:0] low_idx;
  logic [W-1:0] enc_idx;
  logic         enc_err;
  logic         any_set;
  logic         multi_set;
  logic         accept;
  logic         pop;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = out_valid_q && bus.out_ready;

  // Scanning downward leaves the lowest set position; never exceeds N-1.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_vec[i]) low_idx = W'(i);
    end
  end

  assign any_set   = |bus.in_vec;
  assign multi_set = |(bus.in_vec & (bus.in_vec - N'(1)));

  always_comb begin
    enc_idx = '0;
    enc_err = 1'b0;
    if (MODE == 1) begin
      enc_err = !any_set;
      enc_idx = low_idx;
    end else begin
      enc_err = !any_set || multi_set;
      enc_idx = enc_err ? '0 : low_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_idx_q   <= enc_idx;
      out_err_q   <= enc_err;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ONEHOT_ENC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  assign err_cnt = err_cnt_q;

  // Clear wins over a same-cycle error beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (accept && enc_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`endif
endmodule
